// File: rtl/func_sweep_initiator.sv
// Sweeps a 4-D Q8.8 point through the evaluator with a start_func/func_done 4-phase handshake and tracks the min result.
// Optional handshake watchdog: define SWEEP_TIMEOUT_EN.
module func_sweep_initiator #(
  parameter int          N_POINTS       = 10,
  parameter logic [15:0] STEP           = 16'h0040,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [15:0] base_a,
  input  logic [15:0] base_b,
  input  logic [15:0] base_c,
  input  logic [15:0] base_d,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  output logic [15:0] c_out,
  output logic [15:0] d_out,
  output logic        start_func,
  input  logic        func_done,
  input  logic [31:0] z_in,
  input  logic        overflow_in,
  output logic        busy,
  output logic        sweep_done,
  output logic        min_valid,
  output logic [31:0] min_z,
  output logic [7:0]  min_idx,
  output logic [7:0]  ovf_count,
  output logic        timeout_err
);
  typedef enum logic [2:0] {IDLE, LOAD, REQ, REL, ADVANCE, FINISH} state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_POINTS - 1);

  state_t           state_q, state_d;
  logic [3:0][15:0] op_q, op_d;
  logic             start_func_q, start_func_d;
  logic             busy_q, busy_d;
  logic             sweep_done_q, sweep_done_d;
  logic             min_valid_q, min_valid_d;
  logic [31:0]      min_z_q, min_z_d;
  logic [7:0]       min_idx_q, min_idx_d;
  logic [7:0]       ovf_count_q, ovf_count_d;
  logic [7:0]       idx_q, idx_d;
  logic [31:0]      z_cap_q, z_cap_d;
  logic             ovf_cap_q, ovf_cap_d;
  logic             stat_pend_q, stat_pend_d;
`ifdef SWEEP_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    start_func_d = start_func_q;
    busy_d       = busy_q;
    sweep_done_d = 1'b0;
    min_valid_d  = min_valid_q;
    min_z_d      = min_z_q;
    min_idx_d    = min_idx_q;
    ovf_count_d  = ovf_count_q;
    idx_d        = idx_q;
    z_cap_d      = z_cap_q;
    ovf_cap_d    = ovf_cap_q;
    stat_pend_d  = stat_pend_q;
`ifdef SWEEP_TIMEOUT_EN
    tmo_cnt_d     = '0;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      IDLE: if (go) begin
        state_d     = LOAD;
        busy_d      = 1'b1;
        op_d        = {base_d, base_c, base_b, base_a};
        min_valid_d = 1'b0;
        ovf_count_d = 8'd0;
        idx_d       = 8'd0;
`ifdef SWEEP_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
      end
      LOAD: begin
        state_d      = REQ;
        start_func_d = 1'b1;
      end
      REQ: if (func_done) begin
        z_cap_d      = z_in;
        ovf_cap_d    = overflow_in;
        stat_pend_d  = 1'b1;
        start_func_d = 1'b0;
        state_d      = REL;
      end
      REL: begin
        // Statistics fold in exactly once, however long func_done stays high.
        if (stat_pend_q) begin
          stat_pend_d = 1'b0;
          if (ovf_cap_q) begin
            if (ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
          end else if (!min_valid_q || ($signed(z_cap_q) < $signed(min_z_q))) begin
            min_valid_d = 1'b1;
            min_z_d     = z_cap_q;
            min_idx_d   = idx_q;
          end
        end
        if (!func_done) begin
          if (idx_q == LAST_IDX) begin
            state_d      = FINISH;
            sweep_done_d = 1'b1;
            busy_d       = 1'b0;
          end else begin
            state_d = ADVANCE;
          end
        end
      end
      ADVANCE: begin
        for (int i = 0; i < 4; i++) op_d[i] = op_q[i] + STEP;
        idx_d        = idx_q + 8'd1;
        start_func_d = 1'b1;
        state_d      = REQ;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef SWEEP_TIMEOUT_EN
    // Counts only while waiting for the awaited func_done level; abort overrides the case above.
    if ((state_q == REQ && !func_done) || (state_q == REL && func_done)) begin
      if (tmo_cnt_q == TMO_LAST) begin
        timeout_err_d = 1'b1;
        start_func_d  = 1'b0;
        busy_d        = 1'b0;
        sweep_done_d  = 1'b1;
        state_d       = FINISH;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      start_func_q <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      min_valid_q  <= 1'b0;
      min_z_q      <= '0;
      min_idx_q    <= '0;
      ovf_count_q  <= '0;
      idx_q        <= '0;
      z_cap_q      <= '0;
      ovf_cap_q    <= 1'b0;
      stat_pend_q  <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      start_func_q <= start_func_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      min_valid_q  <= min_valid_d;
      min_z_q      <= min_z_d;
      min_idx_q    <= min_idx_d;
      ovf_count_q  <= ovf_count_d;
      idx_q        <= idx_d;
      z_cap_q      <= z_cap_d;
      ovf_cap_q    <= ovf_cap_d;
      stat_pend_q  <= stat_pend_d;
`ifdef SWEEP_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign a_out      = op_q[0];
  assign b_out      = op_q[1];
  assign c_out      = op_q[2];
  assign d_out      = op_q[3];
  assign start_func = start_func_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign min_valid  = min_valid_q;
  assign min_z      = min_z_q;
  assign min_idx    = min_idx_q;
  assign ovf_count  = ovf_count_q;
`ifdef SWEEP_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_func_sweep_initiator.sv
// Directed bench for func_sweep_initiator: evaluator responder, per-point reference model, cycle monitor.
module tb_func_sweep_initiator;
  localparam int NP  = 10;
  localparam int TMO = 16;

  logic        clk = 1'b0, rst = 1'b1, go = 1'b0;
  logic [15:0] base_a = '0, base_b = '0, base_c = '0, base_d = '0;
  logic [15:0] a_out, b_out, c_out, d_out;
  logic        start_func, func_done, overflow_in;
  logic [31:0] z_in;
  logic        busy, sweep_done, min_valid, timeout_err;
  logic [31:0] min_z;
  logic [7:0]  min_idx, ovf_count;

  func_sweep_initiator #(.N_POINTS(NP), .STEP(16'h0040), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .go(go),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .base_d(base_d),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .start_func(start_func), .func_done(func_done), .z_in(z_in), .overflow_in(overflow_in),
    .busy(busy), .sweep_done(sweep_done), .min_valid(min_valid), .min_z(min_z),
    .min_idx(min_idx), .ovf_count(ovf_count), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // Evaluator function: mode 0 = sign-extended sum, mode 1 = (sum)^2 rescaled to Q24.8.
  function automatic logic [31:0] zfun(input logic [15:0] a, b, c, d, input int mode);
    logic signed [31:0] s;
    logic signed [63:0] sq;
    s  = $signed(a) + $signed(b) + $signed(c) + $signed(d);
    sq = 64'(s) * 64'(s);
    return (mode == 1) ? 32'(sq >>> 8) : 32'(s);
  endfunction

  // Reference model: expected points and final statistics of one sweep.
  logic [15:0] ep [16][4];
  logic        m_valid = 1'b0;
  logic [31:0] m_min_z = '0;
  logic [7:0]  m_min_idx = '0, m_ovf = '0;

  task automatic model_sweep(input logic [15:0] ba, bb, bc, bd, input int mode, input logic [15:0] mask);
    logic [31:0] z;
    m_valid = 1'b0;
    m_ovf   = '0;
    for (int i = 0; i < NP; i++) begin
      ep[i][0] = ba + 16'(i * 64);
      ep[i][1] = bb + 16'(i * 64);
      ep[i][2] = bc + 16'(i * 64);
      ep[i][3] = bd + 16'(i * 64);
      z = zfun(ep[i][0], ep[i][1], ep[i][2], ep[i][3], mode);
      if (mask[i]) begin
        if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
      end else if (!m_valid || $signed(z) < $signed(m_min_z)) begin
        m_valid   = 1'b1;
        m_min_z   = z;
        m_min_idx = 8'(i);
      end
    end
  endtask

  // Responder state
  int          r_mode = 0, r_lat = 0, rsp_idx = 0;
  logic [15:0] r_mask = '0;
  bit          silent = 1'b0;

  initial begin
    int rs = 0, wcnt = 0;
    func_done = 1'b0; z_in = '0; overflow_in = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rs = 0; func_done = 1'b0; overflow_in = 1'b0;
      end else begin
        if (rs == 0 && start_func && !silent) begin rs = 1; wcnt = r_lat; end
        if (rs == 1) begin
          if (wcnt == 0) begin
            func_done   = 1'b1;
            overflow_in = r_mask[rsp_idx];
            z_in        = r_mask[rsp_idx] ? 32'h8000_0000 : zfun(a_out, b_out, c_out, d_out, r_mode);
            rs = 2;
          end else wcnt--;
        end else if (rs == 2 && !start_func) begin
          func_done = 1'b0; overflow_in = 1'b0; rsp_idx++; rs = 0;
        end
      end
    end
  end

  // Monitor: operands per request, handshake release, results on sweep_done.
  int          hs = 0, done_cnt = 0, rise_cyc = 0;
  logic [15:0] seen_a [16];
  initial begin
    logic p_sf = 1'b0, p_fd = 1'b0, p_sd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (start_func && !p_sf) begin
          rise_cyc = cyc;
          if (hs < NP) begin
            chk("op_point", {a_out, b_out, c_out, d_out}, {ep[hs][0], ep[hs][1], ep[hs][2], ep[hs][3]});
            seen_a[hs] = a_out;
          end else chk("extra_req", 64'(hs), 64'(NP - 1));
          hs++;
        end else if (start_func && hs > 0 && hs <= NP) begin
          chk("op_stable", {a_out, b_out, c_out, d_out},
              {ep[hs-1][0], ep[hs-1][1], ep[hs-1][2], ep[hs-1][3]});
        end
        if (p_sf && p_fd) chk("sf_release", 64'(start_func), 64'd0);
        if (p_sd) chk("done_width", 64'(sweep_done), 64'd0);
        if (sweep_done) begin
          done_cnt++;
          chk("busy_at_done", 64'(busy), 64'd0);
          if (silent) begin
            chk("timeout_err", 64'(timeout_err), 64'd1);
            chk("timeout_lat", 64'(cyc - rise_cyc), 64'(TMO));
          end else begin
            chk("req_count", 64'(hs), 64'(NP));
            chk("min_valid", 64'(min_valid), 64'(m_valid));
            chk("min_z", 64'(min_z), 64'(m_min_z));
            chk("min_idx", 64'(min_idx), 64'(m_min_idx));
            chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
            chk("timeout_err0", 64'(timeout_err), 64'd0);
          end
        end
      end
      p_sf = rst ? 1'b0 : start_func;
      p_fd = rst ? 1'b0 : func_done;
      p_sd = rst ? 1'b0 : sweep_done;
    end
  end

  task automatic start_sweep(input logic [15:0] ba, bb, bc, bd, input int mode,
                             input logic [15:0] mask, input int lat);
    model_sweep(ba, bb, bc, bd, mode, mask);
    r_mode = mode; r_mask = mask; r_lat = lat; rsp_idx = 0; hs = 0;
    @(negedge clk);
    go = 1'b1; base_a = ba; base_b = bb; base_c = bc; base_d = bd;
    @(negedge clk);
    go = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("op_load", {a_out, b_out, c_out, d_out}, {ba, bb, bc, bd});
    chk("sf_not_yet", 64'(start_func), 64'd0);
    base_a = ~ba; base_b = 16'h1234; base_c = 16'h5555; base_d = ~bd;
    @(negedge clk);
    chk("sf_rise", 64'(start_func), 64'd1);
  endtask

  task automatic wait_done(input int bound);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) chk("sweep_done_seen", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {a_out, b_out, c_out, d_out},
        64'd0);
    chk("rst_flags", {start_func, busy, sweep_done, min_valid, timeout_err, min_z, min_idx, ovf_count},
        64'd0);
    rst = 1'b0;

    // Zero base, sum evaluator
    start_sweep(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 3);
    wait_done(3000);
    chk("lit_last_op", 64'(a_out), 64'h0240);
    chk("lit_min_z0", 64'(min_z), 64'd0);
    chk("lit_min_idx0", 64'(min_idx), 64'd0);
    chk("results_hold", 64'(min_valid), 64'd1);

    // -1.0 .. +1.25, squared sum; go pulsed mid-sweep must be ignored
    start_sweep(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 1, 16'h0000, 0);
    repeat (5) @(negedge clk);
    go = 1'b1; @(negedge clk); go = 1'b0;
    chk("busy_mid", 64'(busy), 64'd1);
    wait_done(3000);
    chk("lit_min_idx4", 64'(min_idx), 64'd4);
    chk("lit_min_z4", 64'(min_z), 64'd0);

    // Overflow on first three points
    start_sweep(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0007, 1);
    wait_done(3000);
    chk("lit_ovf3", 64'(ovf_count), 64'd3);
    chk("lit_min_idx3", 64'(min_idx), 64'd3);
    chk("lit_min_z3", 64'(min_z), 64'd768);

    // Every point overflows
    start_sweep(16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 16'h03FF, 2);
    wait_done(3000);
    chk("lit_all_ovf_valid", 64'(min_valid), 64'd0);
    chk("lit_all_ovf_cnt", 64'(ovf_count), 64'd10);

    // Wraparound
    start_sweep(16'h7FC0, 16'h0100, 16'hFFC0, 16'h8000, 0, 16'h0000, 1);
    wait_done(3000);
    chk("lit_wrap_a", 64'(seen_a[1]), 64'h8000);

    // Reset during third request, then clean restart
    start_sweep(16'h0010, 16'h0020, 16'hFFF0, 16'h0000, 0, 16'h0000, 3);
    for (int i = 0; i < 200 && hs < 3; i++) @(negedge clk);
    chk("third_req_seen", 64'(hs), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_flags", {start_func, busy, sweep_done, min_valid, ovf_count, min_idx}, 64'd0);
    chk("mid_rst_ops", {a_out, b_out, c_out, d_out, min_z}, 64'd0);
    rst = 1'b0;
    m_valid = 1'b0; m_min_z = '0; m_min_idx = '0; m_ovf = '0;
    start_sweep(16'h0010, 16'h0020, 16'hFFF0, 16'h0000, 0, 16'h0000, 2);
    wait_done(3000);

    // Evaluator never answers
    silent = 1'b1;
    start_sweep(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0);
`ifdef SWEEP_TIMEOUT_EN
    wait_done(60);
`else
    repeat (100) @(negedge clk);
    chk("hang_busy", 64'(busy), 64'd1);
    chk("hang_sf", 64'(start_func), 64'd1);
    chk("hang_tmo", 64'(timeout_err), 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("final_rst", {start_func, busy}, 64'd0);
    rst = 1'b0;
    silent = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
